projectile_pool: RTL and testbench

//  Parametrised pool of BULLET_COUNT projectiles, replacing the fixed 8-slot player-bullet controller.

---
 rtl/projectile_pool.sv | 129 ++++++++++++
 tb/tb_projectile_pool.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/projectile_pool.sv
// rtl/projectile_pool.sv - parametrised projectile pool with edge/auto fire, movement ticks and hit clearing
module projectile_pool #(
  parameter int BULLET_COUNT = 8,
  parameter int COORD_W      = 10,
  parameter int STEP_DIV     = 65536,
  parameter int STEP_PX      = 1,
  parameter int DIR_UP       = 1,
  parameter int Y_LIMIT      = 480,
  parameter int X_OFFSET     = 12,
  parameter int AUTO_FIRE    = 0,
  parameter int COOLDOWN     = 8
) (
  input  logic                              clk25,
  input  logic                              rst_n,
  input  logic                              fire_req,
  input  logic [COORD_W-1:0]                spawn_x,
  input  logic [COORD_W-1:0]                spawn_y,
  input  logic [BULLET_COUNT-1:0]           bullet_hit,
  output logic [COORD_W*BULLET_COUNT-1:0]   bullet_x_flat,
  output logic [COORD_W*BULLET_COUNT-1:0]   bullet_y_flat,
  output logic [BULLET_COUNT-1:0]           bullet_active_flat,
  output logic                              fire_ack,
  output logic                              pool_full,
  output logic [$clog2(BULLET_COUNT+1)-1:0] active_count
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int CNT_W = $clog2(BULLET_COUNT + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [CD_W-1:0]    CD_RELOAD = CD_W'(COOLDOWN - 1);
  localparam logic [COORD_W-1:0] X_OFS     = COORD_W'(X_OFFSET);
  localparam logic [COORD_W-1:0] STEP      = COORD_W'(STEP_PX);
  localparam logic [COORD_W:0]   STEP_EXT  = (COORD_W + 1)'(STEP_PX);
  localparam logic [COORD_W:0]   Y_LIM_EXT = (COORD_W + 1)'(Y_LIMIT);

  logic [COORD_W-1:0]      x_q   [BULLET_COUNT];
  logic [COORD_W-1:0]      y_q   [BULLET_COUNT];
  logic [COORD_W-1:0]      x_nxt [BULLET_COUNT];
  logic [COORD_W-1:0]      y_nxt [BULLET_COUNT];
  logic [BULLET_COUNT-1:0] act_q;
  logic [BULLET_COUNT-1:0] act_nxt;
  logic [BULLET_COUNT-1:0] free;
  logic [BULLET_COUNT-1:0] grant;
  logic [BULLET_COUNT-1:0] launch_vec;
  logic [DIV_W-1:0]        div_q;
  logic [CD_W-1:0]         cd_q;
  logic                    fire_d;
  logic                    tick;
  logic                    req;
  logic                    launch;

  assign tick      = (div_q == DIV_LAST);
  assign pool_full = &act_q;

  // Slot choice uses the registered active bits, so a slot freed this cycle waits one cycle.
  assign free       = ~act_q;
  assign grant      = free & (~free + BULLET_COUNT'(1));
  assign req        = (AUTO_FIRE != 0) ? (fire_req && (cd_q == '0)) : (fire_req && !fire_d);
  assign launch     = req && !pool_full;
  assign launch_vec = launch ? grant : '0;

  always_comb begin
    active_count = '0;
    for (int i = 0; i < BULLET_COUNT; i++) begin
      active_count = active_count + CNT_W'(act_q[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < BULLET_COUNT; i++) begin
      x_nxt[i]   = x_q[i];
      y_nxt[i]   = y_q[i];
      act_nxt[i] = act_q[i];
      if (launch_vec[i]) begin
        x_nxt[i]   = spawn_x + X_OFS;
        y_nxt[i]   = spawn_y;
        act_nxt[i] = 1'b1;
      end else if (act_q[i]) begin
        if (bullet_hit[i]) begin
          act_nxt[i] = 1'b0;
        end else if (tick) begin
          // Exit test is done one bit wider so the screen edge never wraps around.
          if (DIR_UP != 0) begin
            if ({1'b0, y_q[i]} < STEP_EXT) act_nxt[i] = 1'b0;
            else                           y_nxt[i]   = y_q[i] - STEP;
          end else begin
            if (({1'b0, y_q[i]} + STEP_EXT) >= Y_LIM_EXT) act_nxt[i] = 1'b0;
            else                                           y_nxt[i]   = y_q[i] + STEP;
          end
        end
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      for (int i = 0; i < BULLET_COUNT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      act_q    <= '0;
      fire_d   <= 1'b0;
      fire_ack <= 1'b0;
      div_q    <= '0;
      cd_q     <= '0;
    end else begin
      for (int i = 0; i < BULLET_COUNT; i++) begin
        x_q[i] <= x_nxt[i];
        y_q[i] <= y_nxt[i];
      end
      act_q    <= act_nxt;
      fire_d   <= fire_req;
      fire_ack <= launch;
      div_q    <= tick ? '0 : div_q + DIV_W'(1);
      if (launch && (AUTO_FIRE != 0)) cd_q <= CD_RELOAD;
      else if (cd_q != '0)            cd_q <= cd_q - CD_W'(1);
    end
  end

  assign bullet_active_flat = act_q;

  for (genvar g = 0; g < BULLET_COUNT; g++) begin : g_flat
    assign bullet_x_flat[g*COORD_W +: COORD_W] = x_q[g];
    assign bullet_y_flat[g*COORD_W +: COORD_W] = y_q[g];
  end

endmodule

// File: tb/tb_projectile_pool.sv
// tb/tb_projectile_pool.sv - directed checks of edge fire, overflow, movement, exit and auto fire
module tb_projectile_pool;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fire_req;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic [3:0] bullet_hit;

  logic [39:0] e_x, e_y, u_x, u_y, d_x, d_y, a_x, a_y;
  logic [3:0]  e_act, u_act, d_act, a_act;
  logic        e_ack, u_ack, d_ack, a_ack;
  logic        e_full, u_full, d_full, a_full;
  logic [2:0]  e_cnt, u_cnt, d_cnt, a_cnt;

  int checks = 0;
  int failures = 0;

  always #20 clk = ~clk;

  projectile_pool #(.BULLET_COUNT(4)) u_edge (
    .clk25(clk), .rst_n(rst_n), .fire_req(fire_req), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .bullet_hit(bullet_hit), .bullet_x_flat(e_x), .bullet_y_flat(e_y), .bullet_active_flat(e_act),
    .fire_ack(e_ack), .pool_full(e_full), .active_count(e_cnt));

  projectile_pool #(.BULLET_COUNT(4), .STEP_DIV(4), .STEP_PX(2), .DIR_UP(1)) u_up (
    .clk25(clk), .rst_n(rst_n), .fire_req(fire_req), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .bullet_hit(bullet_hit), .bullet_x_flat(u_x), .bullet_y_flat(u_y), .bullet_active_flat(u_act),
    .fire_ack(u_ack), .pool_full(u_full), .active_count(u_cnt));

  projectile_pool #(.BULLET_COUNT(4), .STEP_DIV(4), .STEP_PX(1), .DIR_UP(0), .Y_LIMIT(480)) u_down (
    .clk25(clk), .rst_n(rst_n), .fire_req(fire_req), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .bullet_hit(bullet_hit), .bullet_x_flat(d_x), .bullet_y_flat(d_y), .bullet_active_flat(d_act),
    .fire_ack(d_ack), .pool_full(d_full), .active_count(d_cnt));

  projectile_pool #(.BULLET_COUNT(4), .AUTO_FIRE(1), .COOLDOWN(8)) u_auto (
    .clk25(clk), .rst_n(rst_n), .fire_req(fire_req), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .bullet_hit(bullet_hit), .bullet_x_flat(a_x), .bullet_y_flat(a_y), .bullet_active_flat(a_act),
    .fire_ack(a_ack), .pool_full(a_full), .active_count(a_cnt));

  typedef struct {
    logic       fire;
    logic [9:0] sx;
    logic [9:0] sy;
    logic [3:0] hit;
    logic       ack;
    logic [3:0] act;
    logic [2:0] cnt;
    logic       full;
    int         slot;
    logic [9:0] ex;
    logic [9:0] ey;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic f, int sx, int sy, logic [3:0] hit, logic ack, logic [3:0] act,
                              int cnt, logic full, int slot, int ex, int ey);
    vec_t v;
    v.fire = f;     v.sx = 10'(sx);   v.sy = 10'(sy);  v.hit = hit;
    v.ack = ack;    v.act = act;      v.cnt = 3'(cnt); v.full = full;
    v.slot = slot;  v.ex = 10'(ex);   v.ey = 10'(ey);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic f);
    rst_n = 1'b0;
    fire_req = f;
    bullet_hit = '0;
    repeat (2) step();
  endtask

  initial begin
    rst_n = 1'b0; fire_req = 1'b1; spawn_x = '0; spawn_y = '0; bullet_hit = '0;
    repeat (3) step();
    chk("rst_act", e_act, 0);
    chk("rst_ack", e_ack, 0);
    chk("rst_cnt", e_cnt, 0);
    chk("rst_auto_ack", a_ack, 0);

    // Edge fire, fill, overflow, hit refill, freed-slot latency, hit on inactive slot.
    vq.push_back(mk(0, 100, 200, 4'b0000, 0, 4'b0000, 0, 0, 0,   0,   0));
    vq.push_back(mk(1, 100, 200, 4'b0000, 1, 4'b0001, 1, 0, 0, 112, 200));
    vq.push_back(mk(1, 100, 200, 4'b0000, 0, 4'b0001, 1, 0, 0, 112, 200));
    vq.push_back(mk(1, 100, 200, 4'b0000, 0, 4'b0001, 1, 0, 0, 112, 200));
    vq.push_back(mk(1, 100, 200, 4'b0000, 0, 4'b0001, 1, 0, 0, 112, 200));
    vq.push_back(mk(0, 100, 200, 4'b0000, 0, 4'b0001, 1, 0, 0, 112, 200));
    vq.push_back(mk(1,   5,   6, 4'b0000, 1, 4'b0011, 2, 0, 1,  17,   6));
    vq.push_back(mk(0,   5,   6, 4'b0000, 0, 4'b0011, 2, 0, 1,  17,   6));
    vq.push_back(mk(1, 1020,  7, 4'b0000, 1, 4'b0111, 3, 0, 2,   8,   7));
    vq.push_back(mk(0, 1020,  7, 4'b0000, 0, 4'b0111, 3, 0, 2,   8,   7));
    vq.push_back(mk(1,   9,   9, 4'b0000, 1, 4'b1111, 4, 1, 3,  21,   9));
    vq.push_back(mk(0,   9,   9, 4'b0000, 0, 4'b1111, 4, 1, 3,  21,   9));
    vq.push_back(mk(1,  50,  50, 4'b0000, 0, 4'b1111, 4, 1, 0, 112, 200));
    vq.push_back(mk(0,  50,  50, 4'b0010, 0, 4'b1101, 3, 0, 1,  17,   6));
    vq.push_back(mk(1, 300,  40, 4'b0000, 1, 4'b1111, 4, 1, 1, 312,  40));
    vq.push_back(mk(0, 300,  40, 4'b0000, 0, 4'b1111, 4, 1, 1, 312,  40));
    vq.push_back(mk(1,   0,   0, 4'b0100, 0, 4'b1011, 3, 0, 2,   8,   7));
    vq.push_back(mk(0,   0,   0, 4'b0000, 0, 4'b1011, 3, 0, 2,   8,   7));
    vq.push_back(mk(1,   0,   0, 4'b0100, 1, 4'b1111, 4, 1, 2,  12,   0));
    vq.push_back(mk(0,   0,   0, 4'b0000, 0, 4'b1111, 4, 1, 2,  12,   0));

    rst_n = 1'b1; fire_req = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      fire_req = vq[i].fire; spawn_x = vq[i].sx; spawn_y = vq[i].sy; bullet_hit = vq[i].hit;
      step();
      chk($sformatf("v%0d_ack", i),  e_ack,  vq[i].ack);
      chk($sformatf("v%0d_act", i),  e_act,  vq[i].act);
      chk($sformatf("v%0d_cnt", i),  e_cnt,  vq[i].cnt);
      chk($sformatf("v%0d_full", i), e_full, vq[i].full);
      chk($sformatf("v%0d_x", i), e_x[vq[i].slot*10 +: 10], vq[i].ex);
      chk($sformatf("v%0d_y", i), e_y[vq[i].slot*10 +: 10], vq[i].ey);
    end

    // Reset while the pool is full, with fire held high.
    hold_reset(1'b1);
    chk("midrst_act", e_act, 0);
    chk("midrst_ack", e_ack, 0);
    chk("midrst_cnt", e_cnt, 0);
    chk("midrst_y0", e_y[9:0], 0);

    // Upward movement: y=3, step 2, tick every 4 cycles.
    rst_n = 1'b1; fire_req = 1'b1; spawn_x = 10'd0; spawn_y = 10'd3;
    step();
    chk("up_launch_act", u_act[0], 1);
    chk("up_launch_y", u_y[9:0], 3);
    fire_req = 1'b0;
    repeat (2) step();
    chk("up_pretick_y", u_y[9:0], 3);
    step();
    chk("up_tick1_y", u_y[9:0], 1);
    chk("up_tick1_act", u_act[0], 1);
    repeat (3) step();
    chk("up_pretick2_act", u_act[0], 1);
    step();
    chk("up_tick2_act", u_act[0], 0);
    chk("up_tick2_yheld", u_y[9:0], 1);

    // Downward movement to the screen bound.
    hold_reset(1'b0);
    rst_n = 1'b1; fire_req = 1'b1; spawn_y = 10'd478;
    step();
    chk("dn_launch_y", d_y[9:0], 478);
    fire_req = 1'b0;
    repeat (3) step();
    chk("dn_tick1_y", d_y[9:0], 479);
    chk("dn_tick1_act", d_act[0], 1);
    repeat (4) step();
    chk("dn_exit_act", d_act[0], 0);
    chk("dn_exit_yheld", d_y[9:0], 479);

    // Hit in the same cycle as a tick: hit wins and y stays put.
    hold_reset(1'b0);
    rst_n = 1'b1; fire_req = 1'b1; spawn_y = 10'd478;
    step();
    fire_req = 1'b0;
    repeat (2) step();
    bullet_hit = 4'b0001;
    step();
    bullet_hit = 4'b0000;
    chk("dn_hit_act", d_act[0], 0);
    chk("dn_hit_yheld", d_y[9:0], 478);

    // Auto fire with cooldown 8 fills four slots, then retries without acking.
    hold_reset(1'b0);
    rst_n = 1'b1; fire_req = 1'b1; spawn_x = 10'd20; spawn_y = 10'd30;
    for (int k = 0; k < 40; k++) begin
      step();
      chk($sformatf("auto_ack_c%0d", k), a_ack, ((k % 8 == 0) && (k < 32)) ? 1 : 0);
    end
    chk("auto_cnt", a_cnt, 4);
    chk("auto_full", a_full, 1);
    chk("auto_x3", a_x[39:30], 32);
    fire_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
